// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: architectural integer register file, 2 combinational read
// ports and 1 synchronous write port. The highest index (XZR) has no storage
// and always reads as zero.
// Optional build macro: REGFILE_WRITE_BYPASS_EN forwards WriteData to a read
// port whose address matches a live write in the same cycle.
module reg_file_2r1w #(
   parameter int WIDTH  = 64,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] WriteRegister,
   input  logic [WIDTH-1:0]  WriteData,
   input  logic [ADDR_W-1:0] ReadRegister1,
   input  logic [ADDR_W-1:0] ReadRegister2,
   output logic [WIDTH-1:0]  ReadData1,
   output logic [WIDTH-1:0]  ReadData2
);

   localparam int NREGS = 2 ** ADDR_W;
   localparam int XZR   = NREGS - 1;

   typedef logic [WIDTH-1:0] word_t;

   // Physical storage only for indices 0..NREGS-2.
   word_t            regs_q [XZR];
   word_t            regs_d [XZR];
   logic [XZR-1:0]   wr_sel;
   word_t            leaf   [NREGS];
   word_t            rd1_tree;
   word_t            rd2_tree;

   // 2:1 word mux, the building block of the read trees.
   function automatic word_t mux2(input word_t a, input word_t b, input logic s);
      return s ? b : a;
   endfunction

   // NREGS:1 read selection as log2(NREGS) levels of 2:1 muxes, LSB of the
   // address steering the leaf level.
   function automatic word_t read_tree(input logic [ADDR_W-1:0] sel,
                                       input word_t leaves [NREGS]);
      word_t lvl [NREGS];
      lvl = leaves;
      for (int l = 0; l < ADDR_W; l++) begin
         for (int n = 0; n < (NREGS >> (l + 1)); n++) begin
            lvl[n] = mux2(lvl[2*n], lvl[2*n+1], sel[l]);
         end
      end
      return lvl[0];
   endfunction

   // One-hot write decode gated by RegWrite; XZR has no select line.
   always_comb begin
      wr_sel = '0;
      for (int i = 0; i < XZR; i++) begin
         wr_sel[i] = RegWrite && (WriteRegister == ADDR_W'(i));
      end
   end

   // Next-state: selected register takes WriteData, others hold.
   always_comb begin
      for (int i = 0; i < XZR; i++) begin
         regs_d[i] = wr_sel[i] ? WriteData : regs_q[i];
      end
   end

   // Storage update; reset clears every register and overrides any write.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < XZR; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < XZR; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Mux-tree leaves: stored words plus a constant zero in the XZR slot.
   always_comb begin
      for (int i = 0; i < XZR; i++) begin
         leaf[i] = regs_q[i];
      end
      leaf[XZR] = '0;
   end

   // Independent read trees for the two ports.
   always_comb begin
      rd1_tree = read_tree(ReadRegister1, leaf);
      rd2_tree = read_tree(ReadRegister2, leaf);
   end

`ifdef REGFILE_WRITE_BYPASS_EN
   logic wr_live;
   // A write that will commit at the next edge is visible to matching reads now.
   always_comb begin
      wr_live   = RegWrite && !reset && (WriteRegister != ADDR_W'(XZR));
      ReadData1 = (wr_live && (ReadRegister1 == WriteRegister)) ? WriteData : rd1_tree;
      ReadData2 = (wr_live && (ReadRegister2 == WriteRegister)) ? WriteData : rd2_tree;
   end
`else
   // No forwarding: reads always return the stored value.
   always_comb begin
      ReadData1 = rd1_tree;
      ReadData2 = rd2_tree;
   end
`endif

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: directed and randomized bench for reg_file_2r1w with a
// behavioural register-array reference model.
module tb_reg_file_2r1w;

   localparam int WIDTH  = 64;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic              RegWrite;
   logic [ADDR_W-1:0] WriteRegister;
   logic [WIDTH-1:0]  WriteData;
   logic [ADDR_W-1:0] ReadRegister1;
   logic [ADDR_W-1:0] ReadRegister2;
   logic [WIDTH-1:0]  ReadData1;
   logic [WIDTH-1:0]  ReadData2;

   logic [WIDTH-1:0]  mem [0:30];
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reg_file_2r1w #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .RegWrite     (RegWrite),
      .WriteRegister(WriteRegister),
      .WriteData    (WriteData),
      .ReadRegister1(ReadRegister1),
      .ReadRegister2(ReadRegister2),
      .ReadData1    (ReadData1),
      .ReadData2    (ReadData2)
   );

   function automatic logic [WIDTH-1:0] expect_rd(input logic [ADDR_W-1:0] a);
      logic [WIDTH-1:0] r;
      if (a == 5'd31) r = '0;
      else            r = mem[a];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (!reset && RegWrite && WriteRegister != 5'd31 && a == WriteRegister) r = WriteData;
`endif
      return r;
   endfunction

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input string tag, input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
      ReadRegister1 = a1;
      ReadRegister2 = a2;
      #1;
      chk({tag, "/p1"}, ReadData1, expect_rd(a1));
      chk({tag, "/p2"}, ReadData2, expect_rd(a2));
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 31; i++) mem[i] = '0;
      end else if (RegWrite && WriteRegister != 5'd31) begin
         mem[WriteRegister] = WriteData;
      end
      #1;
   endtask

   initial begin
      reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
      ReadRegister1 = '0; ReadRegister2 = '0;
      tick();
      reset = 1'b0;
      rd("reset_state", 5'd0, 5'd30);
      chk("reset_state_const", ReadData2, 64'd0);

      // Reset flush
      RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 64'hDEAD_BEEF_0000_0001;
      tick();
      RegWrite = 1'b0;
      rd("x5_written", 5'd5, 5'd5);
      chk("x5_const", ReadData1, 64'hDEAD_BEEF_0000_0001);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 32; i += 2) begin
         rd("flush", 5'(i), 5'(i + 1));
         chk("flush_const1", ReadData1, 64'd0);
         chk("flush_const2", ReadData2, 64'd0);
         tick();
      end

      // Basic write/read
      RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 64'h0000_0000_0000_00AA;
      tick();
      WriteRegister = 5'd7; WriteData = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      RegWrite = 1'b0;
      rd("basic", 5'd3, 5'd7);
      chk("basic_x3", ReadData1, 64'h0000_0000_0000_00AA);
      chk("basic_x7", ReadData2, 64'hFFFF_FFFF_FFFF_FFFF);
      tick();
      rd("basic_x4", 5'd4, 5'd4);
      chk("basic_x4_const", ReadData1, 64'd0);

      // XZR write ignored, XZR reads zero even with a live write to it
      RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = 64'h1234;
      rd("xzr_live", 5'd31, 5'd31);
      chk("xzr_live_const", ReadData1, 64'd0);
      tick();
      RegWrite = 1'b0;
      rd("xzr_after", 5'd31, 5'd31);
      chk("xzr_after_const", ReadData2, 64'd0);
      tick();
      for (int i = 0; i < 31; i++) begin
         rd("xzr_others", 5'(i), 5'(30 - i));
         tick();
      end

      // Write enable and reset priority
      RegWrite = 1'b0; WriteRegister = 5'd2; WriteData = 64'h55;
      tick();
      rd("we_off", 5'd2, 5'd2);
      chk("we_off_const", ReadData1, 64'd0);
      reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd2; WriteData = 64'h77;
      rd("rst_wr_pre", 5'd2, 5'd3);
      tick();
      reset = 1'b0; RegWrite = 1'b0;
      rd("rst_wr_post", 5'd2, 5'd7);
      chk("rst_wr_x2_const", ReadData1, 64'd0);
      chk("rst_wr_x7_const", ReadData2, 64'd0);
      tick();

      // Read-during-write
      RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 64'h11;
      tick();
      WriteData = 64'h22;
      rd("rdw_pre", 5'd9, 5'd9);
`ifdef REGFILE_WRITE_BYPASS_EN
      chk("rdw_pre_const", ReadData1, 64'h22);
`else
      chk("rdw_pre_const", ReadData1, 64'h11);
`endif
      tick();
      RegWrite = 1'b0;
      rd("rdw_post", 5'd9, 5'd9);
      chk("rdw_post_const", ReadData2, 64'h22);
      tick();

      // Same-address dual read
      RegWrite = 1'b1; WriteRegister = 5'd12; WriteData = 64'h0F0F;
      tick();
      RegWrite = 1'b0;
      rd("dual12", 5'd12, 5'd12);
      chk("dual12_p1_const", ReadData1, 64'h0F0F);
      chk("dual12_p2_const", ReadData2, 64'h0F0F);
      tick();

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic [ADDR_W-1:0] a1;
         logic [ADDR_W-1:0] a2;
         reset         = ($urandom_range(0, 49) == 0);
         RegWrite      = 1'($urandom_range(0, 1));
         WriteRegister = 5'($urandom);
         WriteData     = {$urandom, $urandom};
         a1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom);
         a2 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom);
         rd("rand", a1, a2);
         tick();
      end

      reset = 1'b0; RegWrite = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rd("final_sweep", 5'(i), 5'(31 - i));
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
